// File: rtl/vga_stream_receiver.sv
// rtl/vga_stream_receiver.sv - VGA-style stream sink: timing recovery, format lock, pixel coordinates
module vga_stream_receiver #(
   parameter int LOCK_FRAMES = 2,
   parameter int CW          = 13
) (
   input  logic          iCLK,
   input  logic          iRST_N,
   input  logic          iVGA_H_SYNC,
   input  logic          iVGA_V_SYNC,
   input  logic          iVGA_BLANK,
   input  logic [7:0]    iVGA_R,
   input  logic [7:0]    iVGA_G,
   input  logic [7:0]    iVGA_B,
   output logic          oPixel_Valid,
   output logic [23:0]   oPixel_Data,
   output logic [CW-1:0] oX,
   output logic [CW-1:0] oY,
   output logic          oFrame_Start,
   output logic          oFrame_Done,
   output logic [CW-1:0] oH_Total,
   output logic [CW-1:0] oAct_W,
   output logic [CW-1:0] oAct_H,
   output logic          oLocked,
   output logic          oError
);

   typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_PRE = {{(CW-1){1'b1}}, 1'b0};
   localparam logic [CW-1:0] LOCK_N  = CW'(LOCK_FRAMES);

   // stage-1 samples and their one-cycle-delayed copies for edge detection
   logic          hs_r, vs_r, bl_r;
   logic          hs_d, vs_d, bl_d;
   logic [23:0]   rgb_r;

   // timing counters and last-line measurements
   logic [CW-1:0] h_cnt, x, y;
   logic [CW-1:0] line_total, line_w;

   // lock state and stored reference format
   state_t        state;
   logic [CW-1:0] ref_total, ref_w, ref_h;
   logic [CW-1:0] match_cnt;

   logic          h_start, v_start, bl_fall, timeout;
   logic [CW-1:0] tot_new, tot_eff, w_eff, x_pix, match_nxt;
   logic          meas_ok, h_bad, lock_err, pix_valid;

   assign h_start   = hs_d & ~hs_r;
   assign v_start   = vs_d & ~vs_r;
   assign bl_fall   = bl_d & ~bl_r;
   // fires only on the step into saturation, so a dead hsync reports once
   assign timeout   = ~h_start & (h_cnt == CNT_PRE);
   assign tot_new   = h_cnt + ONE;
   // a V-start coinciding with an H-start judges the line that just closed
   assign tot_eff   = h_start ? tot_new : line_total;
   assign w_eff     = bl_fall ? x : line_w;
   assign x_pix     = h_start ? '0 : x;
   assign meas_ok   = (tot_eff == ref_total) && (w_eff == ref_w) && (y == ref_h);
   assign h_bad     = h_start && (tot_new != ref_total);
   assign lock_err  = v_start ? ~meas_ok : h_bad;
   assign match_nxt = match_cnt + ONE;
   assign pix_valid = bl_r && (state == LOCKED);

   // stage 1: register the raw stream and keep the previous sample of each control
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hs_r  <= 1'b0;
         vs_r  <= 1'b0;
         bl_r  <= 1'b0;
         hs_d  <= 1'b0;
         vs_d  <= 1'b0;
         bl_d  <= 1'b0;
         rgb_r <= '0;
      end else begin
         hs_r  <= iVGA_H_SYNC;
         vs_r  <= iVGA_V_SYNC;
         bl_r  <= iVGA_BLANK;
         hs_d  <= hs_r;
         vs_d  <= vs_r;
         bl_d  <= bl_r;
         rgb_r <= {iVGA_R, iVGA_G, iVGA_B};
      end
   end

   // line/pixel/row counters and per-line measurements
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         h_cnt      <= '0;
         x          <= '0;
         y          <= '0;
         line_total <= '0;
         line_w     <= '0;
      end else begin
         if (h_start) begin
            h_cnt      <= '0;
            line_total <= tot_new;
         end else if (h_cnt != CNT_MAX) begin
            h_cnt <= h_cnt + ONE;
         end

         if (h_start)
            x <= bl_r ? ONE : '0;
         else if (bl_r)
            x <= x + ONE;

         if (bl_fall)
            line_w <= x;

         if (v_start)
            y <= '0;
         else if (bl_fall)
            y <= y + ONE;
      end
   end

   // lock FSM: reference capture, frame matching, loss detection, measurement outputs
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= SEARCH;
         ref_total <= '0;
         ref_w     <= '0;
         ref_h     <= '0;
         match_cnt <= '0;
         oLocked   <= 1'b0;
         oError    <= 1'b0;
         oH_Total  <= '0;
         oAct_W    <= '0;
         oAct_H    <= '0;
      end else begin
         oError <= 1'b0;
         if (timeout) begin
            oError    <= 1'b1;
            oLocked   <= 1'b0;
            match_cnt <= '0;
            state     <= SEARCH;
         end else begin
            case (state)
               SEARCH: begin
                  if (v_start) begin
                     ref_total <= tot_eff;
                     ref_w     <= w_eff;
                     ref_h     <= y;
                     match_cnt <= '0;
                     state     <= CHECK;
                  end
               end
               CHECK: begin
                  if (v_start) begin
                     if (meas_ok) begin
                        match_cnt <= match_nxt;
                        if (match_nxt == LOCK_N) begin
                           state    <= LOCKED;
                           oLocked  <= 1'b1;
                           oH_Total <= tot_eff;
                           oAct_W   <= w_eff;
                           oAct_H   <= y;
                        end
                     end else begin
                        ref_total <= tot_eff;
                        ref_w     <= w_eff;
                        ref_h     <= y;
                        match_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (lock_err) begin
                     oError    <= 1'b1;
                     oLocked   <= 1'b0;
                     ref_total <= tot_eff;
                     ref_w     <= w_eff;
                     ref_h     <= y;
                     match_cnt <= '0;
                     state     <= CHECK;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

   // output register: pixel stream, coordinates and frame markers
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oPixel_Valid <= 1'b0;
         oPixel_Data  <= '0;
         oX           <= '0;
         oY           <= '0;
         oFrame_Start <= 1'b0;
         oFrame_Done  <= 1'b0;
      end else begin
         oPixel_Valid <= pix_valid;
         oPixel_Data  <= pix_valid ? rgb_r : '0;
         oX           <= x_pix;
         oY           <= y;
         oFrame_Start <= pix_valid && (x_pix == '0) && (y == '0);
         oFrame_Done  <= v_start && (state == LOCKED) && (y != '0);
      end
   end

endmodule

// File: tb/tb_vga_stream_receiver.sv
// tb/tb_vga_stream_receiver.sv - scoreboard bench for vga_stream_receiver
module tb_vga_stream_receiver;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        hs = 1'b1, vs = 1'b1, bl = 1'b0;
   logic [7:0]  r = 8'h00, g = 8'h00, b = 8'h00;
   logic        oPixel_Valid, oFrame_Start, oFrame_Done, oLocked, oError;
   logic [23:0] oPixel_Data;
   logic [12:0] oX, oY, oH_Total, oAct_W, oAct_H;

   vga_stream_receiver #(.LOCK_FRAMES(2), .CW(13)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .iVGA_H_SYNC(hs), .iVGA_V_SYNC(vs), .iVGA_BLANK(bl),
      .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
      .oPixel_Valid(oPixel_Valid), .oPixel_Data(oPixel_Data),
      .oX(oX), .oY(oY), .oFrame_Start(oFrame_Start), .oFrame_Done(oFrame_Done),
      .oH_Total(oH_Total), .oAct_W(oAct_W), .oAct_H(oAct_H),
      .oLocked(oLocked), .oError(oError)
   );

   always #5 iCLK = ~iCLK;

   int cyc = 0;
   always @(posedge iCLK) cyc <= cyc + 1;

   typedef struct { int x; int y; logic [23:0] d; } pix_t;
   pix_t sbq[$];

   int checks = 0, failures = 0;
   int H_TOT, H_ACT, HS_S, HS_L, V_TOT, V_ACT, VS_S, VS_L;
   int long_line = -1;
   bit sb_on = 1'b0, rst_req = 1'b0, watch = 1'b0;
   int vs_hist[$];
   int last_hs_cyc = 0, fs_in_cyc = 0;

   int err_cnt = 0, err_cyc = 0, fd_cnt = 0, fs_cnt = 0, fs_out_cyc = 0;
   int lock_rise_cyc = -1, valid_cnt = 0, pix_bad = 0, early_bad = 0;
   int max_x = 0, max_y = 0;
   bit locked_d = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic set_fmt(input int ht, ha, hss, hsl, vt, va, vss, vsl);
      H_TOT = ht; H_ACT = ha; HS_S = hss; HS_L = hsl;
      V_TOT = vt; V_ACT = va; VS_S = vss; VS_L = vsl;
   endtask

   task automatic drive(input logic h, v, a, input logic [7:0] rr, gg, bb);
      @(posedge iCLK);
      #1;
      hs = h; vs = v; bl = a; r = rr; g = gg; b = bb;
   endtask

   task automatic run_frames(input int n);
      for (int f = 0; f < n; f++) begin
         for (int ln = 0; ln < V_TOT; ln++) begin
            int len;
            len = H_TOT + ((ln == long_line) ? 1 : 0);
            for (int h = 0; h < len; h++) begin
               logic       h_n, v_n, act;
               logic [7:0] xr, yr, rr, gg, bb;
               h_n = !(h >= HS_S && h < HS_S + HS_L);
               v_n = !(ln >= VS_S && ln < VS_S + VS_L);
               act = (h < H_ACT) && (ln < V_ACT);
               xr  = 8'(h);
               yr  = 8'(ln);
               rr  = act ? xr : 8'h00;
               gg  = act ? yr : 8'h00;
               bb  = act ? 8'hA5 : 8'h00;
               drive(h_n, v_n, act, rr, gg, bb);
               if (h == HS_S) last_hs_cyc = cyc;
               if (h == 0 && ln == VS_S) vs_hist.push_back(cyc);
               if (sb_on && act) begin
                  if (h == 0 && ln == 0) fs_in_cyc = cyc;
                  sbq.push_back('{h, ln, {xr, yr, 8'hA5}});
               end
               if (rst_req && ln == 10 && h == 20) begin
                  rst_req = 1'b0;
                  iRST_N = 1'b0;
                  #2;
                  check("rst_outputs_zero",
                        longint'(|{oPixel_Valid, oPixel_Data, oX, oY, oFrame_Start, oFrame_Done,
                                   oH_Total, oAct_W, oAct_H, oLocked, oError}), 0);
                  #1;
                  iRST_N = 1'b1;
                  watch = 1'b1;
               end
            end
         end
      end
      long_line = -1;
   endtask

   // monitor: event counters and scoreboard pops on every valid pixel
   always @(negedge iCLK) begin
      pix_t p;
      if (oError) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (oFrame_Done) fd_cnt++;
      if (oFrame_Start) begin
         fs_cnt++;
         fs_out_cyc = cyc;
      end
      if (oLocked && !locked_d) lock_rise_cyc = cyc;
      locked_d = oLocked;
      if (watch && oPixel_Valid && !oLocked) early_bad++;
      if (oPixel_Valid) begin
         valid_cnt++;
         if (int'(oX) > max_x) max_x = int'(oX);
         if (int'(oY) > max_y) max_y = int'(oY);
         if (sbq.size() > 0) begin
            p = sbq.pop_front();
            if (int'(oX) != p.x || int'(oY) != p.y || oPixel_Data !== p.d) pix_bad++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, f0;
      set_fmt(80, 48, 56, 8, 30, 24, 26, 2);
      repeat (3) @(posedge iCLK);
      #1 iRST_N = 1'b1;
      repeat (3) drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      check("reset_locked", longint'(oLocked), 0);
      check("reset_pixel_valid", longint'(oPixel_Valid), 0);
      check("reset_h_total", longint'(oH_Total), 0);
      check("reset_error", longint'(oError), 0);

      // lock from reset, then one fully scoreboarded frame
      vs_hist.delete();
      run_frames(3);
      sb_on = 1'b1;
      run_frames(1);
      sb_on = 1'b0;
      if (vs_hist.size() >= 3)
         check("lock_latency", longint'(lock_rise_cyc - vs_hist[2]), 2);
      else
         check("vstart_count", vs_hist.size(), 3);
      check("h_total", longint'(oH_Total), 80);
      check("act_w", longint'(oAct_W), 48);
      check("act_h", longint'(oAct_H), 24);
      check("valid_pixels", valid_cnt, 48 * 24);
      check("pixel_mismatches", pix_bad, 0);
      check("scoreboard_left", sbq.size(), 0);
      check("max_x", max_x, 47);
      check("max_y", max_y, 23);
      check("frame_start_count", fs_cnt, 1);
      check("frame_start_latency", longint'(fs_out_cyc - fs_in_cyc), 2);
      check("no_error_lock", err_cnt, 0);

      // one 81-clock line while locked
      e0 = err_cnt;
      long_line = 5;
      run_frames(1);
      check("fmt_change_error", err_cnt - e0, 1);
      check("fmt_change_unlock", longint'(oLocked), 0);
      run_frames(1);
      check("fmt_relock_early", longint'(oLocked), 0);
      run_frames(1);
      check("fmt_relock", longint'(oLocked), 1);
      check("fmt_error_total", err_cnt - e0, 1);

      // source outage: hsync stops toggling until the counter saturates
      e0 = err_cnt;
      repeat (8300) drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      check("timeout_error", err_cnt - e0, 1);
      check("timeout_latency", longint'(err_cyc - last_hs_cyc), 8193);
      check("timeout_unlock", longint'(oLocked), 0);
      run_frames(1);
      check("restore_vs1", longint'(oLocked), 0);
      run_frames(1);
      check("restore_vs2", longint'(oLocked), 0);
      run_frames(1);
      check("restore_vs3", longint'(oLocked), 1);
      check("timeout_error_total", err_cnt - e0, 1);

      // asynchronous reset mid-line while locked
      rst_req = 1'b1;
      run_frames(4);
      watch = 1'b0;
      check("valid_before_relock", early_bad, 0);
      check("reset_relock", longint'(oLocked), 1);
      check("reset_act_h", longint'(oAct_H), 24);

      // smaller source format
      set_fmt(40, 16, 24, 4, 16, 12, 13, 1);
      run_frames(3);
      check("small_locked", longint'(oLocked), 1);
      check("small_h_total", longint'(oH_Total), 40);
      check("small_act_w", longint'(oAct_W), 16);
      check("small_act_h", longint'(oAct_H), 12);
      f0 = fd_cnt;
      run_frames(2);
      check("small_frame_done", fd_cnt - f0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
